// File: rtl/spu_sm_sum_reci.sv
// rtl/spu_sm_sum_reci.sv - softmax row-sum accumulator with sequential fixed-point reciprocal
// Build option: define SM_RECI_ROUND_EN for a round-to-nearest reciprocal (default truncates).
module spu_sm_sum_reci #(
  parameter int SUM_W     = 18,
  parameter int RECI_FRAC = 16,
  parameter int RECI_W    = 16
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic [2:0]        sm_state,
  input  logic              din_valid,
  input  logic [3:0]        din_mask,
  input  logic [7:0]        exp_q_0,
  input  logic [7:0]        exp_q_1,
  input  logic [7:0]        exp_q_2,
  input  logic [7:0]        exp_q_3,
  output logic [SUM_W-1:0]  sum_q,
  output logic              sum_sat,
  output logic [RECI_W-1:0] reci_q,
  output logic              reci_valid,
  output logic              reci_busy,
  output logic              div_zero
);

  localparam logic [2:0] SM_IDLE = 3'b000;
  localparam logic [2:0] SM_EU_A = 3'b001;
  localparam logic [2:0] SM_RECI = 3'b011;

  localparam int               CNT_W    = $clog2(RECI_FRAC + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RECI_FRAC);
  localparam logic [SUM_W:0]   SUM_MAX  = {1'b0, {SUM_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} fsm_t;

  fsm_t                 state;
  fsm_t                 state_nxt;
  logic [2:0]           prev_state;
  logic                 in_reci;
  logic                 row_start;
  logic                 load_edge;
  logic [SUM_W:0]       beat_sum;
  logic [SUM_W:0]       acc_sum;
  logic                 acc_ovf;
  logic [SUM_W-1:0]     divisor;
  logic [SUM_W:0]       rem;
  logic [SUM_W:0]       rem_shift;
  logic [SUM_W:0]       rem_nxt;
  logic                 q_bit;
  logic [RECI_FRAC-1:0] quo;
  logic [RECI_FRAC:0]   quo_nxt;
  logic [RECI_FRAC+1:0] quo_fin;
  logic [RECI_W-1:0]    reci_calc;
  logic [CNT_W-1:0]     cnt;

  assign in_reci   = (sm_state == SM_RECI);
  assign row_start = (sm_state == SM_EU_A) && (prev_state != SM_EU_A);
  assign load_edge = in_reci && (prev_state != SM_RECI);

  always_comb begin
    beat_sum = '0;
    if (din_mask[0]) beat_sum = beat_sum + (SUM_W+1)'(exp_q_0);
    if (din_mask[1]) beat_sum = beat_sum + (SUM_W+1)'(exp_q_1);
    if (din_mask[2]) beat_sum = beat_sum + (SUM_W+1)'(exp_q_2);
    if (din_mask[3]) beat_sum = beat_sum + (SUM_W+1)'(exp_q_3);
  end

  // A row start discards the old sum even when the first beat is not valid.
  always_comb begin
    acc_sum = row_start ? '0 : {1'b0, sum_q};
    if (din_valid) acc_sum = acc_sum + beat_sum;
    acc_ovf = (acc_sum > SUM_MAX);
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      sum_sat    <= 1'b0;
      prev_state <= SM_IDLE;
    end else begin
      prev_state <= sm_state;
      if ((sm_state == SM_EU_A) && (row_start || din_valid)) begin
        sum_q   <= acc_ovf ? SUM_MAX[SUM_W-1:0] : acc_sum[SUM_W-1:0];
        sum_sat <= acc_ovf || (sum_sat && !row_start);
      end
    end
  end

  // Restoring step; a bit shifted out of rem guarantees the subtraction succeeds.
  always_comb begin
    rem_shift = {rem[SUM_W-1:0], (cnt == CNT_INIT)};
    q_bit     = rem[SUM_W] || (rem_shift >= {1'b0, divisor});
    rem_nxt   = q_bit ? (rem_shift - {1'b0, divisor}) : rem_shift;
    quo_nxt   = {quo, q_bit};
`ifdef SM_RECI_ROUND_EN
    quo_fin   = {1'b0, quo_nxt} + (RECI_FRAC+2)'({rem_nxt, 1'b0} >= {2'b00, divisor});
`else
    quo_fin   = {1'b0, quo_nxt};
`endif
    reci_calc = (|quo_fin[RECI_FRAC+1:RECI_W]) ? '1 : quo_fin[RECI_W-1:0];
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load_edge) state_nxt = (sum_q == '0) ? S_DONE : S_DIV;
      S_DIV:   if (!in_reci || (cnt == '0)) state_nxt = S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    reci_busy = (state != S_IDLE);
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor    <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      reci_q     <= '0;
      reci_valid <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      reci_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_edge) begin
            divisor <= sum_q;
            rem     <= '0;
            quo     <= '0;
            cnt     <= CNT_INIT;
          end
        end
        S_DIV: begin
          // Leaving RECI aborts silently: result registers keep their old values.
          if (in_reci) begin
            rem <= rem_nxt;
            quo <= quo_nxt[RECI_FRAC-1:0];
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              reci_q     <= reci_calc;
              reci_valid <= 1'b1;
              div_zero   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          reci_q     <= '1;
          div_zero   <= 1'b1;
          reci_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_sm_sum_reci.sv
// tb/tb_spu_sm_sum_reci.sv - scoreboard bench for spu_sm_sum_reci against an arithmetic reference model
module tb_spu_sm_sum_reci;

  localparam int SUM_W     = 18;
  localparam int RECI_FRAC = 16;
  localparam int RECI_W    = 16;
  localparam int SUM_MAX   = (1 << SUM_W) - 1;
  localparam int RECI_MAX  = (1 << RECI_W) - 1;

  localparam logic [2:0] SM_IDLE = 3'b000;
  localparam logic [2:0] SM_EU_A = 3'b001;
  localparam logic [2:0] SM_RECI = 3'b011;
  localparam logic [2:0] SM_EU_B = 3'b100;

  logic              core_clk;
  logic              rst_n;
  logic [2:0]        sm_state;
  logic              din_valid;
  logic [3:0]        din_mask;
  logic [7:0]        exp_q_0, exp_q_1, exp_q_2, exp_q_3;
  logic [SUM_W-1:0]  sum_q;
  logic              sum_sat;
  logic [RECI_W-1:0] reci_q;
  logic              reci_valid;
  logic              reci_busy;
  logic              div_zero;

  spu_sm_sum_reci #(.SUM_W(SUM_W), .RECI_FRAC(RECI_FRAC), .RECI_W(RECI_W)) dut (
    .core_clk   (core_clk),
    .rst_n      (rst_n),
    .sm_state   (sm_state),
    .din_valid  (din_valid),
    .din_mask   (din_mask),
    .exp_q_0    (exp_q_0),
    .exp_q_1    (exp_q_1),
    .exp_q_2    (exp_q_2),
    .exp_q_3    (exp_q_3),
    .sum_q      (sum_q),
    .sum_sat    (sum_sat),
    .reci_q     (reci_q),
    .reci_valid (reci_valid),
    .reci_busy  (reci_busy),
    .div_zero   (div_zero)
  );

  typedef struct {
    int reci;
    int dz;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   msum = 0;
  int   msat = 0;
  int   mreci = 0;

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc = cyc + 1;

  task automatic check(input string name, input longint act, input longint exp_v);
    checks = checks + 1;
    if (act != exp_v) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  function automatic int ref_reci(input int s);
    int q;
    if (s == 0) return RECI_MAX;
    q = (1 << RECI_FRAC) / s;
`ifdef SM_RECI_ROUND_EN
    if (2 * ((1 << RECI_FRAC) % s) >= s) q = q + 1;
`endif
    if (q > RECI_MAX) q = RECI_MAX;
    return q;
  endfunction

  // Monitor: every reci_valid pulse must match the oldest outstanding expectation.
  always @(negedge core_clk) begin
    if (rst_n === 1'b1 && reci_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_reci_valid: got reci_q=%0d with no request outstanding (cycle %0d)", reci_q, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("reci_q", reci_q, e.reci);
        check("div_zero", div_zero, e.dz);
        check("reci_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_row(input int nbeats, input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input bit v, input bit rnd);
    int beat;
    sm_state = SM_EU_A;
    for (int i = 0; i < nbeats; i++) begin
      if (rnd) begin
        m = 4'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
        c = 8'($urandom);
        d = 8'($urandom);
      end
      din_mask  = m;
      exp_q_0   = a;
      exp_q_1   = b;
      exp_q_2   = c;
      exp_q_3   = d;
      din_valid = v;
      beat = 0;
      if (m[0]) beat += int'(a);
      if (m[1]) beat += int'(b);
      if (m[2]) beat += int'(c);
      if (m[3]) beat += int'(d);
      if (i == 0) begin
        msum = v ? beat : 0;
        msat = 0;
      end else if (v) begin
        msum = msum + beat;
      end
      if (msum > SUM_MAX) begin
        msum = SUM_MAX;
        msat = 1;
      end
      step();
    end
    sm_state  = SM_IDLE;
    din_valid = 1'b0;
    step();
    check("sum_q", sum_q, msum);
    check("sum_sat", sum_sat, msat);
  endtask

  task automatic do_reci();
    exp_t e;
    e.reci = ref_reci(msum);
    e.dz   = (msum == 0) ? 1 : 0;
    e.cyc  = cyc + ((msum == 0) ? 2 : RECI_FRAC + 2);
    sbq.push_back(e);
    mreci = e.reci;
    sm_state = SM_RECI;
    step();
    if (msum != 0) check("reci_busy_running", reci_busy, 1);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) step();
    check("reci_request_completed", sbq.size(), 0);
    check("reci_busy_after_done", reci_busy, 0);
    sm_state = SM_EU_B;
    step();
    step();
    check("reci_q_stable_eu_b", reci_q, mreci);
    sm_state = SM_IDLE;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    sm_state  = SM_IDLE;
    din_valid = 1'b0;
    din_mask  = 4'h0;
    exp_q_0   = 8'd0;
    exp_q_1   = 8'd0;
    exp_q_2   = 8'd0;
    exp_q_3   = 8'd0;
    step();
    step();
    check("reset_sum_q", sum_q, 0);
    check("reset_sum_sat", sum_sat, 0);
    check("reset_reci_q", reci_q, 0);
    check("reset_reci_valid", reci_valid, 0);
    check("reset_reci_busy", reci_busy, 0);
    check("reset_div_zero", div_zero, 0);
    rst_n = 1'b1;
    step();

    do_row(1, 4'hF, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    check("row_1020", msum, 1020);
    do_reci();

    do_row(3, 4'hF, 8'd64, 8'd64, 8'd64, 8'd64, 1'b1, 1'b0);
    do_reci();
    do_row(1, 4'b0011, 8'd10, 8'd20, 8'd30, 8'd40, 1'b1, 1'b0);
    do_reci();

    do_row(1, 4'b0001, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    do_reci();
    do_row(1, 4'hF, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0);
    do_reci();

    do_row(258, 4'hF, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    do_reci();
    do_row(1, 4'b0001, 8'd6, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    do_reci();

    // Abort after five RECI edges, then a full restart from the same sum.
    do_row(1, 4'b0101, 8'd100, 8'd0, 8'd77, 8'd0, 1'b1, 1'b0);
    sm_state = SM_RECI;
    for (int i = 0; i < 5; i++) step();
    check("abort_busy_before", reci_busy, 1);
    sm_state = SM_EU_B;
    step();
    check("abort_busy_dropped", reci_busy, 0);
    for (int i = 0; i < 20; i++) step();
    check("abort_reci_q_held", reci_q, mreci);
    check("abort_div_zero_held", div_zero, 0);
    do_reci();

    // Asynchronous reset in the middle of a division.
    do_row(2, 4'hF, 8'd3, 8'd5, 8'd7, 8'd11, 1'b1, 1'b0);
    sm_state = SM_RECI;
    for (int i = 0; i < 8; i++) step();
    rst_n = 1'b0;
    #2;
    check("midrst_sum_q", sum_q, 0);
    check("midrst_sum_sat", sum_sat, 0);
    check("midrst_reci_q", reci_q, 0);
    check("midrst_reci_valid", reci_valid, 0);
    check("midrst_reci_busy", reci_busy, 0);
    check("midrst_div_zero", div_zero, 0);
    msum  = 0;
    msat  = 0;
    mreci = 0;
    sm_state = SM_IDLE;
    step();
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      do_row($urandom_range(1, 4), 4'h0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
      do_reci();
    end

    for (int i = 0; i < 5; i++) step();
    check("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
